// File: rtl/msk_pkg.sv
// Shared constants and helpers for the masked affine datapath.
// The optional refresh stage is compiled in with MSK_REFRESH_EN.
package msk_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;

    // Flat position of share j of bit k in a W*d sharing vector.
    function automatic int share_idx(input int k, input int j, input int d);
        return k * d + j;
    endfunction

endpackage

// File: rtl/msk_affine_lane.sv
// Combinational affine (and, with MSK_REFRESH_EN, refresh) on the d shares of one bit.
// Shares are never recombined; only share 0 sees the public constant.
module msk_affine_lane
    import msk_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [d-1:0] sh_in,
    input  logic         cst,
`ifdef MSK_REFRESH_EN
    input  logic [d-2:0] r,
`endif
    output logic [d-1:0] sh_out
);

    always_comb begin
        sh_out    = sh_in;
        sh_out[0] = sh_in[0] ^ cst;
`ifdef MSK_REFRESH_EN
        // Each fresh mask enters exactly one upper share and share 0, so the
        // unmasked value is unchanged.
        for (int j = 1; j < d; j++) begin
            sh_out[j] = sh_in[j] ^ r[j-1];
        end
        sh_out[0] = sh_out[0] ^ (^r);
`endif
    end

endmodule

// File: rtl/msk_affine_pipe.sv
// Elastic masked affine layer: per-bit share-0 XOR with cst, then a 2-entry FIFO.
// Define MSK_REFRESH_EN to add the fresh-randomness refresh and the rnd/rnd_valid/rnd_cnt ports.
module msk_affine_pipe
    import msk_pkg::*;
#(
    parameter int d = 2,
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*d-1:0]       in_data,
    input  logic [W-1:0]         cst,
`ifdef MSK_REFRESH_EN
    input  logic [W*(d-1)-1:0]   rnd,
    input  logic                 rnd_valid,
    output logic [CNT_W-1:0]     rnd_cnt,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*d-1:0]       out_data
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [1:0]  DEPTH_C = 2'(FIFO_DEPTH);

    logic [PW-1:0]   wptr, rptr;
    logic [1:0]      count;
    logic [W*d-1:0]  mem [FIFO_DEPTH];
    logic [W*d-1:0]  lane_out;
    logic            push, pop;

    genvar k;
    generate
        for (k = 0; k < W; k++) begin : g_lane
            msk_affine_lane #(.d(d)) u_lane (
                .sh_in  (in_data[share_idx(k, 0, d) +: d]),
                .cst    (cst[k]),
`ifdef MSK_REFRESH_EN
                .r      (rnd[k*(d-1) +: (d-1)]),
`endif
                .sh_out (lane_out[share_idx(k, 0, d) +: d])
            );
        end
    endgenerate

    // Handshake: a beat moves on a side only in a cycle where that side's
    // valid and ready are both high at the rising edge; an offered output
    // beat holds data and valid stable until taken.
    always_comb begin
`ifdef MSK_REFRESH_EN
        in_ready = (count < DEPTH_C) && rnd_valid;
`else
        in_ready = (count < DEPTH_C);
`endif
        out_valid = (count != 2'd0);
        out_data  = mem[rptr];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= lane_out;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef MSK_REFRESH_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (push && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rnd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_msk_affine_pipe.sv
// Scoreboarded bench for msk_affine_pipe (default d=2, W=4); also builds with MSK_REFRESH_EN.
module tb_msk_affine_pipe;

    localparam int D = 2;
    localparam int W = 4;
    localparam int N = W * D;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [W-1:0]     cst;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
`ifdef MSK_REFRESH_EN
    logic [W*(D-1)-1:0] rnd;
    logic               rnd_valid;
    logic [15:0]        rnd_cnt;
`endif

    always #5 clk = ~clk;

    msk_affine_pipe #(.d(D), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cst       (cst),
`ifdef MSK_REFRESH_EN
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .rnd_cnt   (rnd_cnt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    logic [N-1:0] exp_q[$];
    logic [W-1:0] val_q[$];
    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unmasked value: XOR of all shares of each bit.
    function automatic logic [W-1:0] unmask(input logic [N-1:0] x);
        logic [W-1:0] v;
        for (int k = 0; k < W; k++) v[k] = ^x[k*D +: D];
        return v;
    endfunction

    // Reference output sharing from the transform rules.
    function automatic logic [N-1:0] ref_shares(input logic [N-1:0] x, input logic [W-1:0] c,
                                                input logic [W*(D-1)-1:0] r, input bit refresh);
        logic [N-1:0] o;
        o = x;
        for (int k = 0; k < W; k++) begin
            o[k*D] = o[k*D] ^ c[k];
            if (refresh) begin
                for (int j = 1; j < D; j++) begin
                    o[k*D+j] = o[k*D+j] ^ r[k*(D-1)+j-1];
                    o[k*D]   = o[k*D]   ^ r[k*(D-1)+j-1];
                end
            end
        end
        return o;
    endfunction

    // Monitor / scoreboard: occupancy model is the queue length.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_rdy;
            logic [N-1:0] e;
            logic [W*(D-1)-1:0] r_now;
            bit refresh;
            exp_rdy = (exp_q.size() < 2);
            r_now   = '0;
            refresh = 1'b0;
`ifdef MSK_REFRESH_EN
            exp_rdy = exp_rdy && rnd_valid;
            r_now   = rnd;
            refresh = 1'b1;
            check("rnd_cnt", 64'(rnd_cnt), 64'(model_cnt));
`endif
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_shares", 64'(out_data), 64'(e));
                    check("out_value", 64'(unmask(out_data)), 64'(val_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shares(in_data, cst, r_now, refresh));
                val_q.push_back(unmask(in_data) ^ cst);
                if (model_cnt < 16'hFFFF) model_cnt++;
            end
        end
    end

    function automatic logic [N-1:0] mask_value(input logic [W-1:0] v);
        logic [N-1:0] x;
        x = N'($urandom());
        for (int k = 0; k < W; k++) x[k*D] = v[k] ^ (^x[k*D+1 +: D-1]);
        return x;
    endfunction

    task automatic drive_beat(input logic [W-1:0] v, input logic [W-1:0] c);
        in_valid = 1'b1;
        in_data  = mask_value(v);
        cst      = c;
`ifdef MSK_REFRESH_EN
        rnd       = (W*(D-1))'($urandom_range(1, (1 << (W*(D-1))) - 1));
        rnd_valid = 1'b1;
`endif
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] v, input logic [W-1:0] c);
        logic rdy;
        int budget;
        budget = 0;
        drive_beat(v, c);
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 200);
        if (!rdy) check("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cst       = '0;
        out_ready = 1'b0;
`ifdef MSK_REFRESH_EN
        rnd       = '0;
        rnd_valid = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_data", 64'(out_data), 64'(0));
        rst_n = 1'b1;

        // Masked NOT of 1010.
        out_ready = 1'b1;
        send(4'b1010, 4'hF);
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: two accepted, third held off.
        out_ready = 1'b0;
        send(4'($urandom()), 4'($urandom()));
        send(4'($urandom()), 4'($urandom()));
        fork
            send(4'($urandom()), 4'($urandom()));
            begin
                repeat (3) @(negedge clk);
                check("held_off_ready", 64'(in_ready), 64'(0));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Streaming at one beat per cycle.
        for (int i = 0; i < 20; i++) send(4'($urandom()), 4'($urandom()));
        repeat (3) @(posedge clk);
        #1;

`ifdef MSK_REFRESH_EN
        rnd_valid = 1'b0;
        in_valid  = 1'b1;
        repeat (3) @(negedge clk);
        check("no_rnd_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rnd_valid = 1'b1;
`endif

        // Reset with a full FIFO.
        out_ready = 1'b0;
        send(4'($urandom()), 4'($urandom()));
        send(4'($urandom()), 4'($urandom()));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        val_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            logic acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) drive_beat(4'($urandom()), 4'($urandom()));
                else in_valid = 1'b0;
            end
`ifdef MSK_REFRESH_EN
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd       = (W*(D-1))'($urandom());
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
